pump_valve_sequencer: RTL and testbench
=======================================

Name: pump_valve_sequencer

Overview:
- Clocked controller that generates the three air-control lines of a 3-valve peristaltic pump and the air lines of NUM_CH downstream isolation valves.
- Dispenses a requested number of pump strokes into one selected channel.
- Successor to the fixed single pump-into-one-valve netlist: channel count, phase timing and stroke count are parametrised, and the valve sequencing is produced in hardware instead of being driven externally.
- Sits between the host command interface and the chip's pneumatic ports.

Parameters:
- NUM_CH, 4: number of downstream outlet valves (>=1).
- PHASE_CYC, 8: clock cycles per pump phase (>=1).
- SETTLE_CYC, 4: clock cycles allowed for an outlet valve to open or close (>=1).
- CNT_W, 8: width of the stroke count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  dispense request valid
- req_ready  out  1  controller can accept a request
- req_ch  in  max(1,$clog2(NUM_CH))  target outlet channel
- req_strokes  in  CNT_W  number of pump strokes to dispense
- abort  in  1  terminate the current dispense
- air_valve1  out  1  pump inlet valve air (1 = pressurised = closed)
- air_dc  out  1  pump displacement chamber air
- air_valve2  out  1  pump outlet valve air
- air_out  out  NUM_CH  outlet valve air, one bit per channel (1 = closed)
- busy  out  1  dispense in progress
- done  out  1  one-cycle completion pulse
- strokes_done  out  CNT_W  strokes completed in the last or current dispense

Behaviour:
- Reset (async assert, sync release) puts the block in IDLE with:
  - air_valve1 = air_dc = air_valve2 = 1 and air_out = all 1s (everything closed)
  - busy = 0, done = 0, strokes_done = 0
  - req_ready = 1 after reset release
- Reset asserted mid-operation forces all air lines to 1 immediately (combinational via the async flops); no done pulse is produced.
- Handshake: a request is accepted on a clock edge where req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - req_ch and req_strokes are captured at acceptance.
  - strokes_done clears to 0 at acceptance.
- FSM states: IDLE, OPEN, PUMP, CLOSE, DONE.
- IDLE -> OPEN on acceptance. Exception: if req_strokes == 0 or req_ch >= NUM_CH, go IDLE -> DONE and open no valve.
- OPEN:
  - air_out[ch] = 0; pump lines stay at 1.
  - Lasts SETTLE_CYC cycles, then goes to PUMP.
- PUMP: each stroke is six phases, each PHASE_CYC cycles long. Values are (v1, dc, v2):
  - P0 = (0,1,1)
  - P1 = (0,0,1)
  - P2 = (1,0,1)
  - P3 = (1,0,0)
  - P4 = (1,1,0)
  - P5 = (1,1,1)
- At the end of P5, strokes_done increments. If strokes_done == captured count, go to CLOSE; otherwise start P0 again.
- CLOSE:
  - air_out all 1s; pump lines at 1.
  - Lasts SETTLE_CYC cycles, then goes to DONE.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - busy = 1 in OPEN, PUMP and CLOSE; 0 in IDLE and DONE.
- Latency: from the acceptance edge, done is high in cycle SETTLE_CYC + 6*PHASE_CYC*N + SETTLE_CYC + 1.
- abort:
  - Sampled in OPEN or PUMP.
  - Takes effect the next cycle: go to CLOSE with pump lines forced to 1. A partially completed stroke is not counted.
  - CLOSE then DONE proceed normally.
  - Ignored in IDLE, CLOSE and DONE.
- Never more than one outlet valve open. Pump lines are at 1 whenever the FSM is not in PUMP.
- req_strokes = 2^CNT_W-1 is legal; the stroke counter does not wrap.
- Phase and settle counters are sized for max(PHASE_CYC, SETTLE_CYC).

Optional Feature:
- Macro: PUMP_REVERSE_EN.
- Defined:
  - Adds input port req_dir (1 bit), captured at acceptance.
  - req_dir = 1 runs the phases in order P5, P4, P3, P2, P1, P0 with v1 and v2 swapped, so the pump draws from the outlet.
  - All timing, counting and abort rules are unchanged.
- Undefined: no req_dir port; forward order only.

Test Plan (defaults NUM_CH=4, PHASE_CYC=8, SETTLE_CYC=4):
- Reset → all air lines 1, air_out = 4'b1111, req_ready = 1, busy = 0, strokes_done = 0.
- Request ch=2, strokes=3 → air_out = 4'b1011 from cycle 1; phase pattern P0..P5 repeated 3 times with each value held 8 cycles; done pulse at cycle 153; strokes_done = 3.
- Request ch=1, strokes=0 → no air_out change, done pulse at cycle 1, strokes_done = 0.
- Request ch=5 (invalid) → same response as zero strokes.
- Request ch=0, strokes=5, abort during stroke 3 (P2) → pump lines go to 1 next cycle, CLOSE for 4 cycles, done pulse, strokes_done = 2.
- Assert rst during PUMP → all outputs return to reset values immediately; no done pulse; req_valid held high afterwards is accepted on the first edge after release.

Source files
------------

// File: rtl/pump_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pump_valve_sequencer
// Description : Sequences the three air lines of a 3-valve peristaltic pump
//               and the air lines of NUM_CH downstream isolation valves. It
//               dispenses a requested number of pump strokes into one
//               selected outlet channel.
//               OPEN settles the outlet valve, PUMP runs six-phase strokes,
//               CLOSE settles the valve shut and DONE pulses completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   req_valid    in   dispense request valid
//   req_ready    out  request accepted when high (IDLE only)
//   req_ch       in   target outlet channel
//   req_strokes  in   number of pump strokes to dispense
//   req_dir      in   (PUMP_REVERSE_EN only) 1 = draw from the outlet
//   abort        in   terminate the current dispense
//   air_valve1   out  pump inlet valve air (1 = pressurised = closed)
//   air_dc       out  pump displacement chamber air
//   air_valve2   out  pump outlet valve air
//   air_out      out  outlet valve air, one bit per channel (1 = closed)
//   busy         out  dispense in progress (OPEN, PUMP, CLOSE)
//   done         out  one-cycle completion pulse
//   strokes_done out  strokes completed in the last or current dispense
// Build option
//   PUMP_REVERSE_EN : adds req_dir and reverse phase order with v1/v2 swapped
// ============================================================================
module pump_valve_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int PHASE_CYC  = 8,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] req_ch,
    input  logic [CNT_W-1:0]                               req_strokes,
`ifdef PUMP_REVERSE_EN
    input  logic                                           req_dir,
`endif
    input  logic                                           abort,
    output logic                                           air_valve1,
    output logic                                           air_dc,
    output logic                                           air_valve2,
    output logic [NUM_CH-1:0]                              air_out,
    output logic                                           busy,
    output logic                                           done,
    output logic [CNT_W-1:0]                               strokes_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMAX  = (PHASE_CYC > SETTLE_CYC) ? PHASE_CYC : SETTLE_CYC;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0] PHASE_LAST  = TMR_W'(PHASE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [2:0]       PHASE_FINAL = 3'd5;
    localparam logic [CH_W:0]    CH_LIMIT    = (CH_W + 1)'(NUM_CH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_PUMP  = 3'd2,
        ST_CLOSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2:0]         phase_q, phase_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   strokes_q, strokes_d;
    logic               dir_q, dir_d;

    logic               w_req_dir;
    logic               w_req_null;
    logic [CNT_W-1:0]   w_strokes_inc;
    logic [2:0]         w_eff_phase;
    logic [2:0]         w_pattern;

`ifdef PUMP_REVERSE_EN
    assign w_req_dir = req_dir;
`else
    assign w_req_dir = 1'b0;
`endif

    // A zero-stroke or out-of-range request completes without opening a valve.
    assign w_req_null    = (req_strokes == '0) || ({1'b0, req_ch} >= CH_LIMIT);
    assign w_strokes_inc = strokes_q + CNT_W'(1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            phase_q   <= '0;
            ch_q      <= '0;
            target_q  <= '0;
            strokes_q <= '0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            phase_q   <= phase_d;
            ch_q      <= ch_d;
            target_q  <= target_d;
            strokes_q <= strokes_d;
            dir_q     <= dir_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        phase_d   = phase_q;
        ch_d      = ch_q;
        target_d  = target_q;
        strokes_d = strokes_q;
        dir_d     = dir_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ch_d      = req_ch;
                    target_d  = req_strokes;
                    dir_d     = w_req_dir;
                    strokes_d = '0;
                    tmr_d     = '0;
                    phase_d   = '0;
                    state_d   = w_req_null ? ST_DONE : ST_OPEN;
                end
            end

            ST_OPEN: begin
                if (abort) begin
                    state_d = ST_CLOSE;
                    tmr_d   = '0;
                end else if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_PUMP;
                    tmr_d   = '0;
                    phase_d = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            ST_PUMP: begin
                if (tmr_q == PHASE_LAST) begin
                    tmr_d = '0;
                    if (phase_q == PHASE_FINAL) begin
                        // Stroke finished: count it. The compare uses the
                        // incremented value, so the counter stops at the
                        // target and never wraps even for an all-ones count.
                        phase_d   = '0;
                        strokes_d = w_strokes_inc;
                        if (w_strokes_inc == target_q) begin
                            state_d = ST_CLOSE;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
                // Abort overrides phase sequencing; a stroke is only counted
                // if its final phase ends on this same edge.
                if (abort) begin
                    state_d = ST_CLOSE;
                    tmr_d   = '0;
                end
            end

            ST_CLOSE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_DONE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Pump phase pattern (v1, dc, v2). Reverse runs P5..P0 with v1/v2 swapped.
    // ------------------------------------------------------------------------
    always_comb begin
        w_eff_phase = dir_q ? (PHASE_FINAL - phase_q) : phase_q;
        case (w_eff_phase)
            3'd0:    w_pattern = 3'b011;
            3'd1:    w_pattern = 3'b001;
            3'd2:    w_pattern = 3'b101;
            3'd3:    w_pattern = 3'b100;
            3'd4:    w_pattern = 3'b110;
            default: w_pattern = 3'b111;
        endcase
        if (dir_q) begin
            w_pattern = {w_pattern[0], w_pattern[1], w_pattern[2]};
        end
    end

    // ------------------------------------------------------------------------
    // Outputs decoded from registered state only, so an asynchronous reset
    // closes every air line immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        air_valve1 = 1'b1;
        air_dc     = 1'b1;
        air_valve2 = 1'b1;
        air_out    = '1;
        if (state_q == ST_PUMP) begin
            {air_valve1, air_dc, air_valve2} = w_pattern;
        end
        if ((state_q == ST_OPEN) || (state_q == ST_PUMP)) begin
            // Only the captured channel opens; ch_q is always in range here.
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == CH_W'(i)) begin
                    air_out[i] = 1'b0;
                end
            end
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q == ST_OPEN) || (state_q == ST_PUMP) ||
                          (state_q == ST_CLOSE);
    assign done         = (state_q == ST_DONE);
    assign strokes_done = strokes_q;

endmodule
`default_nettype wire

// File: tb/tb_pump_valve_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pump_valve_sequencer
// Description : Table-driven self-checking bench for pump_valve_sequencer.
//               DUT A uses default parameters, DUT B a small 3-channel,
//               one-cycle-phase configuration with a 4-bit stroke count.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pump_valve_sequencer;

    localparam int A_CH = 4, A_P = 8, A_S = 4, A_W = 8;
    localparam int B_CH = 3, B_P = 1, B_S = 1, B_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             a_req_valid, a_req_ready, a_abort;
    logic [1:0]       a_req_ch;
    logic [A_W-1:0]   a_req_strokes, a_sd;
    logic             a_v1, a_dc, a_v2, a_busy, a_done;
    logic [A_CH-1:0]  a_air_out;

    logic             b_req_valid, b_req_ready, b_abort;
    logic [1:0]       b_req_ch;
    logic [B_W-1:0]   b_req_strokes, b_sd;
    logic             b_v1, b_dc, b_v2, b_busy, b_done;
    logic [B_CH-1:0]  b_air_out;

    pump_valve_sequencer #(
        .NUM_CH(A_CH), .PHASE_CYC(A_P), .SETTLE_CYC(A_S), .CNT_W(A_W)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_ch(a_req_ch), .req_strokes(a_req_strokes), .abort(a_abort),
        .air_valve1(a_v1), .air_dc(a_dc), .air_valve2(a_v2),
        .air_out(a_air_out), .busy(a_busy), .done(a_done),
        .strokes_done(a_sd)
    );

    pump_valve_sequencer #(
        .NUM_CH(B_CH), .PHASE_CYC(B_P), .SETTLE_CYC(B_S), .CNT_W(B_W)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_ch(b_req_ch), .req_strokes(b_req_strokes), .abort(b_abort),
        .air_valve1(b_v1), .air_dc(b_dc), .air_valve2(b_v2),
        .air_out(b_air_out), .busy(b_busy), .done(b_done),
        .strokes_done(b_sd)
    );

    typedef struct {
        int dut;       // 0 = DUT A, 1 = DUT B
        int ch;
        int n;         // requested strokes
        int a;         // abort cycle (0 = none)
        int exp_done;  // hand-computed done cycle after acceptance
        int exp_sd;    // hand-computed final strokes_done
    } vec_t;

    vec_t vecs[8];
    int   errors = 0;
    int   checks = 0;

    // Snapshot layout: [17:15] v1,dc,v2  [14:11] air_out  [10] busy
    //                  [9] done  [8] req_ready  [7:0] strokes_done
    localparam logic [17:0] RESET_SNAP = {3'b111, 4'b1111, 1'b0, 1'b0, 1'b1, 8'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] snap(input int d);
        if (d == 0)
            return {a_v1, a_dc, a_v2, a_air_out, a_busy, a_done, a_req_ready, a_sd};
        else
            return {b_v1, b_dc, b_v2, 1'b1, b_air_out, b_busy, b_done, b_req_ready,
                    4'b0000, b_sd};
    endfunction

    // Reference model: outputs in cycle c after the acceptance edge.
    function automatic logic [17:0] exp_snap(input int d, input int ch, input int n,
                                             input int a, input int c);
        int s, p, nc, last_act, done_c, st, e, sd;
        logic [2:0] pat;
        logic [3:0] air;
        s  = (d == 0) ? A_S  : B_S;
        p  = (d == 0) ? A_P  : B_P;
        nc = (d == 0) ? A_CH : B_CH;
        if (n != 0 && ch < nc) begin
            last_act = (a != 0) ? a : s + 6 * p * n;
            done_c   = last_act + s + 1;
        end else begin
            last_act = 0;
            done_c   = 1;
        end
        if (c == done_c)        st = 4;
        else if (c > done_c)    st = 0;
        else if (c <= last_act) st = (c <= s) ? 1 : 2;
        else                    st = 3;
        pat = 3'b111;
        if (st == 2) begin
            case (((c - s - 1) / p) % 6)
                0:       pat = 3'b011;
                1:       pat = 3'b001;
                2:       pat = 3'b101;
                3:       pat = 3'b100;
                4:       pat = 3'b110;
                default: pat = 3'b111;
            endcase
        end
        air = 4'b1111;
        if (st == 1 || st == 2) air = ~(4'b0001 << ch);
        e  = (((c - 1) < last_act) ? (c - 1) : last_act) - s;
        sd = (e <= 0) ? 0 : e / (6 * p);
        return {pat, air, (st >= 1 && st <= 3), (st == 4), (st == 0), 8'(sd)};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic [17:0] act;
        @(negedge clk);
        if (v.dut == 0) begin
            a_req_valid = 1'b1; a_req_ch = 2'(v.ch); a_req_strokes = 8'(v.n);
        end else begin
            b_req_valid = 1'b1; b_req_ch = 2'(v.ch); b_req_strokes = 4'(v.n);
        end
        act = snap(v.dut);
        check($sformatf("v%0d ready_before_accept", idx), 32'(act[8]), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= v.exp_done + 1; c++) begin
            @(negedge clk);
            a_req_valid = 1'b0;
            b_req_valid = 1'b0;
            act = snap(v.dut);
            check($sformatf("v%0d cyc%0d outputs", idx, c), 32'(act),
                  32'(exp_snap(v.dut, v.ch, v.n, v.a, c)));
            if (c == v.exp_done) begin
                check($sformatf("v%0d done_pulse", idx), 32'(act[9]), 32'd1);
                check($sformatf("v%0d strokes_done", idx), 32'(act[7:0]), 32'(v.exp_sd));
            end
            a_abort = (v.dut == 0) && (v.a != 0) && (c == v.a);
            b_abort = (v.dut == 1) && (v.a != 0) && (c == v.a);
        end
        a_abort = 1'b0;
        b_abort = 1'b0;
    endtask

    initial begin
        logic [17:0] act;
        //                dut ch   n    a  done  sd
        vecs[0] = '{0, 2,  3,   0, 153, 3};
        vecs[1] = '{0, 1,  0,   0,   1, 0};
        vecs[2] = '{0, 0,  5, 120, 125, 2};
        vecs[3] = '{0, 3,  1,   0,  57, 1};
        vecs[4] = '{0, 1,  2,   3,   8, 0};
        vecs[5] = '{1, 3,  2,   0,   1, 0};
        vecs[6] = '{1, 2,  2,   0,  15, 2};
        vecs[7] = '{1, 0, 15,   0,  93, 15};

        rst = 1'b1;
        a_req_valid = 1'b0; a_req_ch = '0; a_req_strokes = '0; a_abort = 1'b0;
        b_req_valid = 1'b0; b_req_ch = '0; b_req_strokes = '0; b_abort = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state_a", 32'(snap(0)), 32'(RESET_SNAP));
        check("reset_state_b", 32'(snap(1)), 32'(RESET_SNAP));

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a pump stroke.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_ch = 2'd2; a_req_strokes = 8'd3;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        repeat (29) @(negedge clk);
        act = snap(0);
        check("pre_reset_pump", 32'(act), 32'(exp_snap(0, 2, 3, 0, 30)));
        #2;
        rst = 1'b1;
        a_req_valid = 1'b1; a_req_ch = 2'd1; a_req_strokes = 8'd1;
        #1;
        check("async_reset_outputs", 32'(snap(0)), 32'(RESET_SNAP));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", k), 32'(snap(0)), 32'(RESET_SNAP));
        end
        #1 rst = 1'b0;
        #1;
        check("after_release", 32'(snap(0)), 32'(RESET_SNAP));
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        check("accept_after_release", 32'(snap(0)),
              32'({3'b111, 4'b1101, 1'b1, 1'b0, 1'b0, 8'd0}));
        for (int c = 2; c <= 58; c++) begin
            @(negedge clk);
            check($sformatf("post_reset cyc%0d", c), 32'(snap(0)),
                  32'(exp_snap(0, 1, 1, 0, c)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
